// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative 14-bit binary to 4-digit packed BCD (double dabble).
// A conversion takes one shift per clock, so latency is constant.
// Define BIN2BCD_SATURATE_EN to show 9999 on overflow; without it, overflow shows EEEE.
module bin2bcd_seq (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [13:0] bin_i,
   output logic [15:0] bcd_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        ovf_o
);

`ifdef BIN2BCD_SATURATE_EN
   localparam logic [15:0] OVF_BCD = 16'h9999;
`else
   localparam logic [15:0] OVF_BCD = 16'hEEEE;
`endif

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t      state_q, state_d;
   logic [29:0] sr_q;
   logic [3:0]  cnt_q;
   logic        ovf_q;
   logic [15:0] adj;
   logic [29:0] shifted;

   genvar g;
   for (g = 0; g < 4; g++) begin : g_nib
      assign adj[4*g +: 4] = (sr_q[14+4*g +: 4] >= 4'd5) ? sr_q[14+4*g +: 4] + 4'd3
                                                         : sr_q[14+4*g +: 4];
   end

   assign shifted = {adj, sr_q[13:0]} << 1;
   assign busy_o  = (state_q != IDLE);

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state: accept in IDLE, run 14 shifts, spend one cycle in DONE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = start_i ? CONV : IDLE;
         CONV:    state_d = (cnt_q == 4'd0) ? DONE : CONV;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Shift register, step counter and overflow flag
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sr_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (state_q == IDLE && start_i) begin
         sr_q  <= {16'h0000, bin_i};
         cnt_q <= 4'd13;
         ovf_q <= (bin_i > 14'd9999);
      end else if (state_q == CONV) begin
         sr_q  <= shifted;
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Result registers only move when a conversion completes
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bcd_o  <= 16'h0000;
         ovf_o  <= 1'b0;
         done_o <= 1'b0;
      end else begin
         done_o <= (state_q == DONE);
         if (state_q == DONE) begin
            bcd_o <= ovf_q ? OVF_BCD : sr_q[29:14];
            ovf_o <= ovf_q;
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq against a decimal-digit reference.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SATURATE_EN
   localparam logic [15:0] SUB = 16'h9999;
`else
   localparam logic [15:0] SUB = 16'hEEEE;
`endif

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      int          acc;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [13:0] bin_i = '0;
   logic [15:0] bcd_o;
   logic        busy_o, done_o, ovf_o;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   exp_t        sb[$];
   logic [15:0] last_bcd = 16'h0000;
   logic        last_ovf = 1'b0;

   bin2bcd_seq dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .bin_i(bin_i),
      .bcd_o(bcd_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      int          p;
      r = '0;
      p = 1;
      if (v > 9999) return SUB;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Monitor: pops on each done pulse, otherwise insists the result is held
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (done_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done_o), 32'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("bcd", 32'(bcd_o), 32'(e.bcd));
               chk("ovf", 32'(ovf_o), 32'(e.ovf));
               chk("latency", 32'(cyc - e.acc), 32'(15));
               chk("busy_at_done", 32'(busy_o), 32'(0));
               last_bcd = e.bcd;
               last_ovf = e.ovf;
            end
         end else begin
            chk("bcd_held", 32'(bcd_o), 32'(last_bcd));
            chk("ovf_held", 32'(ovf_o), 32'(last_ovf));
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 40 && busy_o; i++) tick();
      if (busy_o) chk("idle_timeout", 32'(busy_o), 32'(0));
   endtask

   task automatic convert(input int v, input bit push);
      exp_t e;
      wait_idle();
      start_i = 1'b1;
      bin_i   = 14'(v);
      e.bcd   = ref_bcd(v);
      e.ovf   = (v > 9999);
      e.acc   = cyc + 1;
      if (push) sb.push_back(e);
      tick();
      start_i = 1'b0;
      chk("busy_after_accept", 32'(busy_o), 32'(1));
   endtask

   initial begin
      int base;
      int vals[12] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 16383};
      repeat (3) tick();
      chk("rst_bcd", 32'(bcd_o), 32'(0));
      chk("rst_busy", 32'(busy_o), 32'(0));
      chk("rst_done", 32'(done_o), 32'(0));
      chk("rst_ovf", 32'(ovf_o), 32'(0));
      rst_ni = 1'b1;
      tick();

      convert(1234, 1);
      repeat (13) tick();
      chk("busy_late_conv", 32'(busy_o), 32'(1));
      wait_idle();

      // start held high: three conversions at 16-cycle spacing
      wait_idle();
      repeat (2) tick();
      base = cyc + 1;
      start_i = 1'b1;
      bin_i = 14'd0;
      sb.push_back('{16'h0000, 1'b0, base});
      tick();
      bin_i = 14'd9999;
      sb.push_back('{16'h9999, 1'b0, base + 16});
      repeat (16) tick();
      bin_i = 14'd1000;
      sb.push_back('{16'h1000, 1'b0, base + 32});
      repeat (16) tick();
      start_i = 1'b0;
      wait_idle();

      convert(10000, 1);
      convert(16383, 1);
      convert(42, 1);

      // ignored start and bin_i churn during a conversion
      convert(5678, 1);
      repeat (4) begin
         bin_i = 14'($urandom);
         tick();
      end
      start_i = 1'b1;
      bin_i = 14'd1111;
      tick();
      start_i = 1'b0;
      repeat (8) begin
         bin_i = 14'($urandom);
         tick();
      end
      wait_idle();

      // reset mid-conversion aborts without a done pulse
      convert(4321, 0);
      repeat (6) tick();
      rst_ni = 1'b0;
      tick();
      last_bcd = 16'h0000;
      last_ovf = 1'b0;
      rst_ni = 1'b1;
      chk("abort_busy", 32'(busy_o), 32'(0));
      chk("abort_bcd", 32'(bcd_o), 32'(0));
      chk("abort_ovf", 32'(ovf_o), 32'(0));
      repeat (20) tick();
      convert(77, 1);

      foreach (vals[i]) convert(vals[i], 1);
      repeat (400) convert(int'($urandom_range(0, 9999)), 1);
      repeat (50) convert(int'($urandom_range(0, 16383)), 1);

      wait_idle();
      repeat (4) tick();
      chk("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
